// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I load/store unit.
//   F3_*         funct3 width/sign encodings for loads and stores
//   LOAD/STORE   major opcode values the core decodes into LSU requests
//   lsu_state_t  LSU control state
package rv32i_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned F3_W_B = 3;

    localparam logic [F3_W_B-1:0] F3_B  = 3'b000;
    localparam logic [F3_W_B-1:0] F3_H  = 3'b001;
    localparam logic [F3_W_B-1:0] F3_W  = 3'b010;
    localparam logic [F3_W_B-1:0] F3_BU = 3'b100;
    localparam logic [F3_W_B-1:0] F3_HU = 3'b101;

    localparam logic [4:0] LOAD  = 5'b00000;
    localparam logic [4:0] STORE = 5'b01000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   addr_lo, funct3, store : access offset within the word, width/sign, direction
//   wdata, rdata           : raw store data (lane 0) and raw bus read word
//   wstrb_c, wdata_c       : store byte enables and lane-replicated store data
//   load_c                 : extracted and extended load result
//   misalign_c, illegal_c  : access not naturally aligned / funct3 not valid for direction
module rv32i_lsu_align
    import rv32i_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [F3_W_B-1:0] funct3,
    input  logic              store,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [STRB_W-1:0] wstrb_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic [XLEN-1:0]   load_c,
    output logic              misalign_c,
    output logic              illegal_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane selection from the read word
    assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
    assign half_v = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Width decode: strobes, store lanes, load extension, legality
    always_comb begin
        wstrb_c    = '0;
        wdata_c    = '0;
        load_c     = '0;
        misalign_c = 1'b0;
        illegal_c  = 1'b0;
        case (funct3)
            F3_B: begin
                wstrb_c = STRB_W'(4'b0001 << addr_lo);
                wdata_c = {4{wdata[7:0]}};
                load_c  = {{24{byte_v[7]}}, byte_v};
            end
            F3_H: begin
                wstrb_c    = STRB_W'(4'b0011 << {addr_lo[1], 1'b0});
                wdata_c    = {2{wdata[15:0]}};
                load_c     = {{16{half_v[15]}}, half_v};
                misalign_c = addr_lo[0];
            end
            F3_W: begin
                wstrb_c    = 4'b1111;
                wdata_c    = wdata;
                load_c     = rdata;
                misalign_c = (addr_lo != 2'b00);
            end
            F3_BU: begin
                load_c    = {24'd0, byte_v};
                illegal_c = store;
            end
            F3_HU: begin
                load_c     = {16'd0, half_v};
                misalign_c = addr_lo[0];
                illegal_c  = store;
            end
            default: illegal_c = 1'b1;
        endcase
        // Reads never drive strobes
        if (!store) begin
            wstrb_c = '0;
        end
    end

endmodule

// File: rtl/rv32i_lsu.sv
// Load/store unit: accepts one decoded load/store at a time from the core,
// runs a single valid/ready bus transfer and returns one response.
//   clk, reset_n            : clock, async active-low reset
//   req_*                   : request handshake and decoded fields
//   resp_*                  : completion pulse with register-file write info
//   mem_*                   : word-addressed data-memory bus
// Parameter TIMEOUT: bus cycles without mem_ready before a bus error (0 = never).
module rv32i_lsu
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [F3_W_B-1:0] req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              resp_valid,
    output logic              resp_we,
    output logic [RD_W-1:0]   resp_rd,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    lsu_state_t        state;
    logic              lat_store;
    logic [F3_W_B-1:0] lat_funct3;
    logic [1:0]        lat_addr_lo;
    logic [RD_W-1:0]   lat_rd;
    logic [CNT_W-1:0]  tmo_cnt;

    logic              is_idle;
    logic [1:0]        al_addr_lo;
    logic [F3_W_B-1:0] al_funct3;
    logic              al_store;
    logic [STRB_W-1:0] wstrb_c;
    logic [XLEN-1:0]   wdata_c;
    logic [XLEN-1:0]   load_c;
    logic              misalign_c;
    logic              illegal_c;
    logic              timeout_hit;

    // Shared align path sees the live request in IDLE, the latched one afterwards
    assign is_idle    = (state == ST_IDLE);
    assign al_addr_lo = is_idle ? req_addr[1:0] : lat_addr_lo;
    assign al_funct3  = is_idle ? req_funct3 : lat_funct3;
    assign al_store   = is_idle ? req_store : lat_store;

    assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    rv32i_lsu_align u_align (
        .addr_lo    (al_addr_lo),
        .funct3     (al_funct3),
        .store      (al_store),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .wstrb_c    (wstrb_c),
        .wdata_c    (wdata_c),
        .load_c     (load_c),
        .misalign_c (misalign_c),
        .illegal_c  (illegal_c)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_we     <= 1'b0;
            resp_rd     <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wstrb   <= '0;
            mem_wdata   <= '0;
            lat_store   <= 1'b0;
            lat_funct3  <= '0;
            lat_addr_lo <= '0;
            lat_rd      <= '0;
            tmo_cnt     <= '0;
        end else begin
            // Response flags are single-cycle
            resp_valid <= 1'b0;
            resp_we    <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_store   <= req_store;
                        lat_funct3  <= req_funct3;
                        lat_addr_lo <= req_addr[1:0];
                        lat_rd      <= req_rd;
                        req_ready   <= 1'b0;
                        if (misalign_c || illegal_c) begin
                            // Rejected without touching the bus
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            resp_rd    <= req_rd;
                        end else begin
                            state     <= ST_BUS;
                            mem_valid <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_wstrb <= wstrb_c;
                            mem_wdata <= req_store ? wdata_c : '0;
                            tmo_cnt   <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    if (mem_ready || timeout_hit) begin
                        state      <= ST_RESP;
                        mem_valid  <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wstrb  <= '0;
                        resp_valid <= 1'b1;
                        resp_rd    <= lat_rd;
                        if (mem_ready) begin
                            resp_we   <= !lat_store && (lat_rd != '0);
                            resp_data <= lat_store ? '0 : load_c;
                        end else begin
                            resp_err  <= 1'b1;
                            resp_data <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu: stimulus pushes expected bus transfers and
// responses from an arithmetic reference model; a bus responder and a response
// monitor pop and compare independently.
module tb_rv32i_lsu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        resp_valid;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        int          cycles;
    } bus_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        logic        is_load;
        int          lat;
        int          issue_cyc;
    } resp_t;

    bus_t  bus_q[$];
    resp_t exp_q[$];

    rv32i_lsu #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: behaviour from access size, offset and sign rules
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         output logic err, output logic [3:0] strb,
                         output logic [31:0] wlane, output logic [31:0] data);
        int unsigned off, size;
        logic [31:0] sh, b, h;
        logic legal;
        off   = int'(a[1:0]);
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err   = !legal || ((off % size) != 0);
        sh    = rdat >> (8 * off);
        b     = sh & 32'hFF;
        h     = sh & 32'hFFFF;
        strb  = 4'(((1 << size) - 1) << off);
        case (f3)
            3'd0:    begin data = (b >= 128) ? b - 32'd256 : b;     wlane = (wd & 32'hFF) * 32'h01010101; end
            3'd1:    begin data = (h >= 32768) ? h - 32'd65536 : h; wlane = (wd & 32'hFFFF) * 32'h00010001; end
            3'd4:    begin data = b; wlane = 0; end
            3'd5:    begin data = h; wlane = 0; end
            default: begin data = rdat; wlane = wd; end
        endcase
        if (st || err) data = 0;
    endtask

    // Issue one request, push expectations, optionally wait for its response
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] rdat, input int dly, input bit wait_done);
        logic err;
        logic [3:0] strb;
        logic [31:0] wlane, data;
        bus_t  be;
        resp_t re;
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) flag("req_ready_wait");
        model(st, f3, a, wd, rdat, err, strb, wlane, data);
        be.we     = st;
        be.addr   = {a[31:2], 2'b00};
        be.wstrb  = st ? strb : 4'b0000;
        be.wdata  = wlane;
        be.rdata  = rdat;
        be.delay  = dly;
        be.cycles = (dly >= 16) ? 16 : dly + 1;
        re.err       = err || (dly >= 16);
        re.we        = !st && !re.err && (rd != 0);
        re.rd        = rd;
        re.data      = re.err ? 32'd0 : data;
        re.is_load   = !st;
        re.lat       = err ? 1 : be.cycles + 1;
        re.issue_cyc = cyc;
        if (!err) bus_q.push_back(be);
        exp_q.push_back(re);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
        if (wait_done) begin
            n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) begin
                flag("resp_wait");
                exp_q.delete();
            end
        end
    endtask

    // Memory responder: checks bus fields every active cycle, answers after delay
    bus_t cur;
    bit   in_bus = 0;
    int   bc = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            in_bus    = 0;
            mem_ready = 1'b0;
        end else if (mem_valid) begin
            if (!in_bus) begin
                if (bus_q.size() == 0) begin
                    flag("unexpected_bus");
                end else begin
                    cur    = bus_q.pop_front();
                    in_bus = 1;
                    bc     = 0;
                end
            end
            if (in_bus) begin
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
                if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                if (bc == cur.delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = cur.rdata;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
                bc++;
            end else begin
                mem_ready = 1'b1;
            end
        end else begin
            if (in_bus) begin
                chk("bus_cycles", 32'(bc), 32'(cur.cycles));
                in_bus = 0;
            end
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
        end
    end

    // Response monitor
    resp_t er;
    always @(negedge clk) begin
        if (reset_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                flag("unexpected_resp");
            end else begin
                er = exp_q.pop_front();
                chk("resp_err", 32'(resp_err), 32'(er.err));
                chk("resp_we", 32'(resp_we), 32'(er.we));
                chk("resp_data", resp_data, er.data);
                if (er.is_load && !er.err) chk("resp_rd", 32'(resp_rd), 32'(er.rd));
                chk("resp_latency", 32'(cyc - er.issue_cyc), 32'(er.lat));
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3;
        logic [2:0] legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_we", 32'(resp_we), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Directed cases
        issue(1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd1, 32'h0, 0, 1);  // SW
        issue(1, 3'd0, 32'h103, 32'h000000A5, 5'd1, 32'h0, 0, 1);  // SB
        issue(1, 3'd1, 32'h102, 32'h00001234, 5'd1, 32'h0, 1, 1);  // SH
        issue(0, 3'd0, 32'h201, 32'h0, 5'd5, 32'h000080FF, 0, 1);  // LB
        issue(0, 3'd4, 32'h201, 32'h0, 5'd5, 32'h000080FF, 0, 1);  // LBU
        issue(0, 3'd5, 32'h202, 32'h0, 5'd7, 32'h80010000, 2, 1);  // LHU
        issue(0, 3'd1, 32'h202, 32'h0, 5'd7, 32'h80010000, 0, 1);  // LH
        issue(0, 3'd2, 32'h300, 32'h0, 5'd0, 32'hCAFEF00D, 0, 1);  // LW rd=0
        issue(0, 3'd2, 32'h102, 32'h0, 5'd3, 32'h0, 0, 1);         // LW misaligned
        issue(0, 3'd1, 32'h201, 32'h0, 5'd3, 32'h0, 0, 1);         // LH misaligned
        issue(0, 3'd3, 32'h200, 32'h0, 5'd3, 32'h0, 0, 1);         // illegal load
        issue(1, 3'd4, 32'h200, 32'h0, 5'd3, 32'h0, 0, 1);         // illegal store
        issue(0, 3'd2, 32'h400, 32'h0, 5'd9, 32'h12345678, 100, 1); // timeout
        issue(0, 3'd2, 32'h404, 32'h0, 5'd9, 32'h87654321, 3, 1);   // late ready
        issue(0, 3'd2, 32'h408, 32'h0, 5'd9, 32'h0, 15, 1);         // ready on last cycle

        // Reset in the middle of a bus transfer
        issue(0, 3'd2, 32'h500, 32'h0, 5'd4, 32'h11111111, 100, 0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        bus_q.delete();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        issue(0, 3'd2, 32'h504, 32'h0, 5'd4, 32'h22222222, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int dly;
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
            else f3 = legal_f3[$urandom_range(0, 4)];
            dly = ($urandom_range(0, 11) == 0) ? 40 : int'($urandom_range(0, 3));
            issue(1'($urandom), f3, $urandom, $urandom, 5'($urandom), $urandom, dly, 1);
        end

        repeat (5) @(negedge clk);
        chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
